// File: rtl/sha256_iter_core.sv
// Iterative SHA-256/SHA-224 compression core: chains H across pre-padded 512-bit blocks,
// ROUNDS_PER_CYCLE unrolled rounds per clock, digest held on a valid/ready output.

module sha256_round (
    input  logic [0:7][31:0]  st,
    input  logic [0:15][31:0] w,
    input  logic [31:0]       k,
    output logic [0:7][31:0]  st_nx,
    output logic [0:15][31:0] w_nx
);
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    logic [31:0] t1, t2, wn;

    // w[0] is W[t] for this round; the window slides by one and appends W[t+16]
    always_comb begin
        t1    = st[7] + bsig1(st[4]) + ((st[4] & st[5]) ^ (~st[4] & st[6])) + k + w[0];
        t2    = bsig0(st[0]) + ((st[0] & st[1]) ^ (st[0] & st[2]) ^ (st[1] & st[2]));
        wn    = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
        st_nx = {t1 + t2, st[0], st[1], st[2], st[3] + t1, st[4], st[5], st[6]};
        w_nx  = {w[1:15], wn};
    end
endmodule

module sha256_iter_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_block,
    input  logic         in_first,
    input  logic         in_last,
    input  logic         in_sha224,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_digest
);
    localparam int R = ROUNDS_PER_CYCLE;

    generate
        if (!(R == 1 || R == 2 || R == 4 || R == 8 || R == 16 || R == 32 || R == 64)) begin : g_bad_r
            $error("sha256_iter_core: ROUNDS_PER_CYCLE must be a power of two in 1..64");
        end
    endgenerate

    localparam logic [0:7][31:0] IV256 =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [0:7][31:0] IV224 =
        256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

    localparam logic [0:63][31:0] KTAB = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {IDLE, RUN, FINAL, HOLD} state_t;

    state_t             state;
    logic [6:0]         cnt;
    logic [0:7][31:0]   hreg, work, hsum;
    logic [0:15][31:0]  win;
    logic               chain_open, mode224, last_r;

    logic [R:0][0:7][31:0]  st_c;
    logic [R:0][0:15][31:0] w_c;

    assign in_ready = (state == IDLE) && !rst;
    assign st_c[0]  = work;
    assign w_c[0]   = win;

    generate
        for (genvar i = 0; i < R; i++) begin : g_rnd
            logic [5:0] kidx;
            assign kidx = cnt[5:0] + 6'(i);
            sha256_round u_rnd (
                .st   (st_c[i]),
                .w    (w_c[i]),
                .k    (KTAB[kidx]),
                .st_nx(st_c[i+1]),
                .w_nx (w_c[i+1])
            );
        end
    endgenerate

    always_comb begin
        hsum = '0;
        for (int j = 0; j < 8; j++) hsum[j] = hreg[j] + work[j];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            hreg       <= '0;
            work       <= '0;
            win        <= '0;
            chain_open <= 1'b0;
            mode224    <= 1'b0;
            last_r     <= 1'b0;
            out_valid  <= 1'b0;
            out_digest <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    win    <= in_block;
                    last_r <= in_last;
                    cnt    <= '0;
                    state  <= RUN;
                    // a continuation block with no open chain starts a fresh message
                    if (in_first || !chain_open) begin
                        hreg       <= in_sha224 ? IV224 : IV256;
                        work       <= in_sha224 ? IV224 : IV256;
                        mode224    <= in_sha224;
                        chain_open <= 1'b1;
                    end else begin
                        work <= hreg;
                    end
                end
                RUN: begin
                    work <= st_c[R];
                    win  <= w_c[R];
                    cnt  <= cnt + 7'(R);
                    if (cnt + 7'(R) == 7'd64) state <= FINAL;
                end
                FINAL: begin
                    hreg <= hsum;
                    cnt  <= '0;
                    if (last_r) begin
                        out_digest <= mode224 ? {hsum[0:6], 32'h0} : 256'(hsum);
                        chain_open <= 1'b0;
                        out_valid  <= 1'b1;
                        state      <= HOLD;
                    end else begin
                        state <= IDLE;
                    end
                end
                HOLD: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_iter_core.sv
// Scoreboard bench for sha256_iter_core: known-answer digests, backpressure, mid-run reset,
// and randomized multi-block chains checked against an array-based SHA-256 reference.

module tb_sha256_iter_core;
    localparam int R   = 4;
    localparam int LAT = 64 / R + 1;

    localparam logic [255:0] IV256 =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] IV224 =
        256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 416'h0, 64'h18};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_2A    = 512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000;
    localparam logic [511:0] BLK_2B    = {448'h0, 64'h1c0};

    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] D_224   = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7_00000000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [511:0] in_block = '0;
    logic         in_first = 1'b0;
    logic         in_last = 1'b0;
    logic         in_sha224 = 1'b0;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_digest;

    logic [1:0]   rdy_mode = 2'd1;   // 0: hold low, 1: hold high, 2: random
    logic         rnd_bit = 1'b1;
    assign out_ready = (rdy_mode == 2'd2) ? rnd_bit : rdy_mode[0];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [255:0] d;
        int           acc;
    } exp_t;
    exp_t q[$];

    logic [255:0] m_h = '0;
    bit           m_mode = 1'b0;
    bit           m_open = 1'b0;

    sha256_iter_core #(.ROUNDS_PER_CYCLE(R)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_sha224 (in_sha224),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_digest(out_digest)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Straight FIPS 180-4 compression over a full 64-entry message schedule
    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1;
        logic [255:0] r;
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
        return r;
    endfunction

    function automatic logic [511:0] rnd_block();
        logic [511:0] b;
        for (int j = 0; j < 16; j++) b[511 - 32*j -: 32] = $urandom;
        return b;
    endfunction

    // Junk is presented while in_ready is low; the real block only on the handshake cycle.
    task automatic send(input logic [511:0] blk, input bit first, input bit last, input bit s224,
                        input bit kat, input logic [255:0] kd);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (in_ready) begin
                in_valid = 1'b1; in_block = blk; in_first = first; in_last = last; in_sha224 = s224;
                ok = 1'b1;
                break;
            end
            in_valid  = ($urandom_range(0, 1) == 1);
            in_block  = rnd_block();
            in_first  = ($urandom_range(0, 1) == 1);
            in_last   = ($urandom_range(0, 1) == 1);
            in_sha224 = ($urandom_range(0, 1) == 1);
        end
        if (!ok) begin
            chk("accept_timeout", 256'(in_ready), 256'(1));
            return;
        end
        e.acc = cyc + 1;
        if (first || !m_open) begin
            m_h    = s224 ? IV224 : IV256;
            m_mode = s224;
            m_open = 1'b1;
        end
        m_h = compress(m_h, blk);
        if (last) begin
            e.d = kat ? kd : (m_mode ? {m_h[255:32], 32'h0} : m_h);
            q.push_back(e);
            m_open = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_block = rnd_block();
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && (q.size() != 0 || out_valid); i++) @(negedge clk);
        chk("drain_pending", 256'(q.size()), 256'(0));
    endtask

    // Monitor: pops on each new presentation, then checks the held digest every cycle
    initial begin
        bit           prev_v;
        logic [255:0] held;
        exp_t         e;
        prev_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                chk("hold_in_ready", 256'(in_ready), 256'(0));
                if (!prev_v) begin
                    if (q.size() == 0) begin
                        chk("unexpected_out", 256'(out_valid), 256'(0));
                    end else begin
                        e = q.pop_front();
                        chk("digest", out_digest, e.d);
                        chk("latency", 256'(cyc - e.acc), 256'(LAT));
                    end
                    held = out_digest;
                end else begin
                    chk("hold_stable", out_digest, held);
                end
            end
            prev_v = out_valid;
        end
    end

    initial forever begin
        @(negedge clk);
        rnd_bit = ($urandom_range(0, 2) != 0);
    end

    initial begin
        repeat (60000) @(posedge clk);
        n_bad++;
        $display("FAIL watchdog: cycle budget exhausted, queue depth %0d", q.size());
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        int nb;
        bit f;
        #3;
        chk("rst_in_ready", 256'(in_ready), 256'(0));
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_out_digest", out_digest, 256'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release_in_ready", 256'(in_ready), 256'(1));

        rdy_mode = 2'd1;
        send(BLK_ABC, 1, 1, 0, 1, D_ABC);
        send(BLK_EMPTY, 1, 1, 0, 1, D_EMPTY);
        send(BLK_2A, 1, 0, 0, 0, '0);
        send(BLK_2B, 0, 1, 1, 1, D_TWO);          // in_sha224 on continuation must be ignored
        send(BLK_ABC, 1, 1, 1, 1, D_224);
        send(BLK_2A, 1, 0, 1, 0, '0);
        send(BLK_2B, 0, 1, 0, 0, '0);
        send(BLK_EMPTY, 0, 1, 0, 1, D_EMPTY);     // in_first=0 after a closed chain starts fresh
        drain();

        rdy_mode = 2'd0;
        send(BLK_ABC, 1, 1, 0, 1, D_ABC);
        for (int i = 0; i < 200 && !out_valid; i++) @(negedge clk);
        chk("bp_reached_hold", 256'(out_valid), 256'(1));
        repeat (20) @(negedge clk);
        chk("bp_still_valid", 256'(out_valid), 256'(1));
        rdy_mode = 2'd1;
        @(negedge clk);
        chk("bp_release_valid", 256'(out_valid), 256'(0));
        chk("bp_release_ready", 256'(in_ready), 256'(1));

        send(BLK_2A, 1, 0, 0, 0, '0);
        send(BLK_2B, 0, 1, 0, 0, '0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrun_rst_valid", 256'(out_valid), 256'(0));
        chk("midrun_rst_ready", 256'(in_ready), 256'(0));
        q.delete();
        m_open = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrun_release_ready", 256'(in_ready), 256'(1));
        send(BLK_ABC, 0, 1, 0, 1, D_ABC);
        drain();

        rdy_mode = 2'd2;
        for (int m = 0; m < 30; m++) begin
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                f = (b == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
                send(rnd_block(), f, (b == nb - 1), ($urandom_range(0, 1) == 1), 0, '0);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rdy_mode = 2'd1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
